// File: rtl/fir_mac_param.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_param
// Description : Time-multiplexed FIR filter. One signed multiplier walks the
//               TAPS-deep delay line once per accepted sample, accumulating
//               at full precision. The sum is then rounded (half-up,
//               arithmetic shift by OUT_SHIFT), saturated to DATA_W bits and
//               presented as a one-cycle output pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        rising-edge clock
//   reset        in   1        asynchronous, active-low reset
//   in_data      in   DATA_W   signed input sample
//   in_data_vld  in   1        in_data is valid
//   in_data_rdy  out  1        sample can be accepted (IDLE only)
//   coef_wr      in   1        coefficient write strobe (honoured in IDLE)
//   coef_addr    in   AW       tap index for the write
//   coef_data    in   COEF_W   signed coefficient
//   out_data     out  DATA_W   rounded, saturated result (held between pulses)
//   out_data_vld out  1        one-cycle result strobe
//   out_sat      out  1        result was clipped (only with out_data_vld)
// Legal parameters: TAPS 2..64, OUT_SHIFT 1..COEF_W-2.
// ============================================================================
module fir_mac_param #(
  parameter  int DATA_W    = 8,
  parameter  int COEF_W    = 8,
  parameter  int TAPS      = 8,
  parameter  int OUT_SHIFT = 6,
  localparam int AW        = $clog2(TAPS),
  localparam int ACC_W     = DATA_W + COEF_W + AW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_data_vld,
  output logic                     in_data_rdy,
  input  logic                     coef_wr,
  input  logic        [AW-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_data_vld,
  output logic                     out_sat
);

  localparam int PROD_W = DATA_W + COEF_W;

  localparam logic        [AW-1:0]     C_LAST_IDX = AW'(TAPS - 1);
  localparam logic signed [COEF_W-1:0] C_UNITY    = COEF_W'(2 ** OUT_SHIFT);
  localparam logic signed [ACC_W-1:0]  C_RND      = ACC_W'(2 ** (OUT_SHIFT - 1));
  localparam logic signed [ACC_W-1:0]  C_OUT_MAX  = ACC_W'((2 ** (DATA_W - 1)) - 1);
  // Bitwise inverse of the positive limit is exactly -2^(DATA_W-1).
  localparam logic signed [ACC_W-1:0]  C_OUT_MIN  = ~C_OUT_MAX;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                     state_q;
  logic signed [DATA_W-1:0]   x_q [TAPS];
  logic signed [COEF_W-1:0]   c_q [TAPS];
  logic        [AW-1:0]       idx_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [DATA_W-1:0]   out_data_q;
  logic                       out_vld_q;
  logic                       out_sat_q;

  logic                       w_addr_ok;
  logic                       w_coef_we;
  logic signed [DATA_W-1:0]   w_x_sel;
  logic signed [COEF_W-1:0]   w_c_sel;
  logic        [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    w_rnd_sum;
  logic signed [ACC_W-1:0]    w_shifted;
  logic signed [DATA_W-1:0]   out_data_d;
  logic                       out_sat_d;

  // When TAPS is not a power of two some addresses have no tap behind them;
  // writes to them are dropped.
  generate
    if (TAPS == (2 ** AW)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_partial
      assign w_addr_ok = (coef_addr <= C_LAST_IDX);
    end
  endgenerate

  assign w_coef_we = (state_q == S_IDLE) && coef_wr && w_addr_ok;

  // Single shared multiplier. Both operands are sign-extended to the product
  // width so the low PROD_W bits of the unsigned product are the exact
  // signed product.
  assign w_x_sel    = x_q[idx_q];
  assign w_c_sel    = c_q[idx_q];
  assign w_prod     = {{COEF_W{w_x_sel[DATA_W-1]}}, w_x_sel}
                    * {{DATA_W{w_c_sel[COEF_W-1]}}, w_c_sel};
  assign w_prod_ext = {{AW{w_prod[PROD_W-1]}}, w_prod};
  assign acc_d      = acc_q + w_prod_ext;

  // The AW guard bits keep acc + rounding constant far from overflow.
  assign w_rnd_sum  = acc_q + C_RND;
  assign w_shifted  = w_rnd_sum >>> OUT_SHIFT;

  always_comb begin
    out_data_d = w_shifted[DATA_W-1:0];
    out_sat_d  = 1'b0;
    if (w_shifted > C_OUT_MAX) begin
      out_data_d = C_OUT_MAX[DATA_W-1:0];
      out_sat_d  = 1'b1;
    end else if (w_shifted < C_OUT_MIN) begin
      out_data_d = C_OUT_MIN[DATA_W-1:0];
      out_sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
      out_sat_q  <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= (k == 0) ? C_UNITY : '0;
      end
    end else begin
      out_vld_q <= 1'b0;
      out_sat_q <= 1'b0;

      // A write landing on the accept edge is visible to that sample's MAC
      // pass, which starts reading coefficients on the following edge.
      if (w_coef_we) begin
        c_q[coef_addr] <= coef_data;
      end

      case (state_q)
        S_IDLE: begin
          if (in_data_vld) begin
            x_q[0] <= in_data;
            for (int k = 1; k < TAPS; k++) begin
              x_q[k] <= x_q[k-1];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_MAC;
          end
        end

        S_MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + AW'(1);
          if (idx_q == C_LAST_IDX) begin
            state_q <= S_OUT;
          end
        end

        S_OUT: begin
          out_data_q <= out_data_d;
          out_vld_q  <= 1'b1;
          out_sat_q  <= out_sat_d;
          state_q    <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_data_rdy  = (state_q == S_IDLE);
  assign out_data     = out_data_q;
  assign out_data_vld = out_vld_q;
  assign out_sat      = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_param
// Description : Scoreboard bench for fir_mac_param with default parameters.
//               Stimulus pushes hand-computed results; a negedge monitor pops
//               and compares data, saturation flag and arrival cycle, and
//               checks that out_data holds and out_sat stays low between
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_param;

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int TAPS      = 8;
  localparam int OUT_SHIFT = 6;
  localparam int AW        = 3;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     in_data_vld = 1'b0;
  logic                     in_data_rdy;
  logic                     coef_wr = 1'b0;
  logic        [AW-1:0]     coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_data_vld;
  logic                     out_sat;

  typedef struct {
    logic signed [DATA_W-1:0] data;
    logic                     sat;
    int                       cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic signed [DATA_W-1:0] last_out = '0;

  fir_mac_param #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_data_vld (in_data_vld),
    .in_data_rdy (in_data_rdy),
    .coef_wr     (coef_wr),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .out_data    (out_data),
    .out_data_vld(out_data_vld),
    .out_sat     (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      last_out = '0;
    end else if (out_data_vld) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got data=%0d sat=%0b at cycle %0d, required no output",
                 out_data, out_sat, cyc);
      end else begin
        e_m = sb.pop_front();
        if (out_data !== e_m.data) begin
          n_bad++;
          $display("FAIL out_data: got %0d, required %0d", out_data, e_m.data);
        end
        n_cmp++;
        if (out_sat !== e_m.sat) begin
          n_bad++;
          $display("FAIL out_sat: got %0b, required %0b (data %0d)", out_sat, e_m.sat, e_m.data);
        end
        n_cmp++;
        if (cyc != e_m.cyc) begin
          n_bad++;
          $display("FAIL latency: output at cycle %0d, required cycle %0d", cyc, e_m.cyc);
        end
      end
      last_out = out_data;
    end else begin
      n_cmp++;
      if (out_sat !== 1'b0) begin
        n_bad++;
        $display("FAIL sat_idle: got out_sat=%0b without valid, required 0", out_sat);
      end
      n_cmp++;
      if (out_data !== last_out) begin
        n_bad++;
        $display("FAIL hold: got out_data=%0d between pulses, required %0d", out_data, last_out);
      end
    end
  end

  task automatic chk(input string name, input int got, input int req);
    n_cmp++;
    if (got != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_rdy", int'(in_data_rdy), 1);
    chk("rst_vld", int'(out_data_vld), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(out_sat), 0);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  // Leaves in_data_vld high; callers drop it when not streaming.
  task automatic send(input logic signed [DATA_W-1:0] v, input logic push,
                      input logic signed [DATA_W-1:0] ev, input logic es);
    int n = 0;
    @(negedge clk);
    while (!in_data_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_data_rdy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got rdy=0 for %0d cycles, required 1", n);
      return;
    end
    in_data     = v;
    in_data_vld = 1'b1;
    @(posedge clk);
    #1;
    if (push) sb.push_back('{ev, es, cyc + TAPS + 1});
  endtask

  task automatic wcoef(input logic [AW-1:0] a, input logic signed [COEF_W-1:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_data_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    coef_addr = a;
    coef_data = d;
    coef_wr   = 1'b1;
    @(posedge clk);
    #1 coef_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
      sb.delete();
    end
  endtask

  logic signed [DATA_W-1:0] neg_exp [8] = '{127, 127, 127, -4, -128, -128, -128, -128};
  logic                     neg_sat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    do_reset();

    // Identity filter out of reset
    send(8'sd5, 1'b1, 8'sd5, 1'b0);     in_data_vld = 1'b0;
    send(-8'sd3, 1'b1, -8'sd3, 1'b0);   in_data_vld = 1'b0;
    send(8'sd100, 1'b1, 8'sd100, 1'b0); in_data_vld = 1'b0;
    drain();

    // Rounding, with the coefficient write on the same edge as the accept:
    // 63*65 = 4095, (4095+32)>>6 = 64
    @(negedge clk);
    chk("idle_rdy", int'(in_data_rdy), 1);
    coef_addr   = '0;
    coef_data   = 8'sd65;
    coef_wr     = 1'b1;
    in_data     = 8'sd63;
    in_data_vld = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{8'sd64, 1'b0, cyc + TAPS + 1});
    coef_wr     = 1'b0;
    in_data_vld = 1'b0;
    drain();

    // Impulse response with c[k] = k+1
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(AW'(k), COEF_W'(k + 1));
    send(8'sd64, 1'b1, 8'sd1, 1'b0); in_data_vld = 1'b0;
    for (int k = 1; k < TAPS; k++) begin
      send(8'sd0, 1'b1, DATA_W'(k + 1), 1'b0);
      in_data_vld = 1'b0;
    end
    drain();

    // Saturation, all c = 63. Line starts as {0,..,0,64}; 64 falls off first.
    for (int k = 0; k < TAPS; k++) wcoef(AW'(k), 8'sd63);
    send(8'sd127, 1'b1, 8'sd125, 1'b0); in_data_vld = 1'b0;  // 8001+32 >> 6
    for (int k = 1; k < TAPS; k++) begin
      send(8'sd127, 1'b1, 8'sd127, 1'b1);
      in_data_vld = 1'b0;
    end
    for (int k = 0; k < TAPS; k++) begin
      send(-8'sd128, 1'b1, neg_exp[k], neg_sat[k]);
      in_data_vld = 1'b0;
    end
    drain();

    // Held valid across busy cycles, plus a write attempted during MAC
    do_reset();
    send(8'sd1, 1'b1, 8'sd1, 1'b0);
    coef_addr = '0;
    coef_data = '0;
    coef_wr   = 1'b1;
    repeat (3) @(posedge clk);
    #1 coef_wr = 1'b0;
    send(8'sd2, 1'b1, 8'sd2, 1'b0);
    send(8'sd3, 1'b1, 8'sd3, 1'b0);
    in_data_vld = 1'b0;
    drain();
    repeat (TAPS + 4) @(negedge clk);

    // Reset in the middle of a MAC pass
    send(8'sd9, 1'b0, 8'sd0, 1'b0);
    in_data_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_vld", int'(out_data_vld), 0);
    chk("abort_rdy", int'(in_data_rdy), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (TAPS + 4) @(negedge clk);
    send(8'sd7, 1'b1, 8'sd7, 1'b0);
    in_data_vld = 1'b0;
    drain();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, required finish", $time);
    $fatal(1, "bench timed out");
  end

endmodule
`default_nettype wire

// File: doc/fir_mac_param.md
FIR_MAC_PARAM -- requirements
Module: fir_mac_param

Interface
REQ-001 Parameter DATA_W, default 8, shall set the signed two's-complement input and output sample width.
REQ-002 Parameter COEF_W, default 8, shall set the signed coefficient width.
REQ-003 Parameter TAPS, default 8, shall set the filter length; the legal range is 2..64.
REQ-004 Parameter OUT_SHIFT, default 6, shall set the output scaling right-shift; the legal range is 1..COEF_W-2.
REQ-005 Derived widths: AW = clog2(TAPS); ACC_W = DATA_W + COEF_W + AW.
REQ-006 Port clk, input, 1 bit: the single clock; all state shall update on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset; reset=0 shall force the reset state immediately.
REQ-008 Port in_data, input, DATA_W bits: signed input sample.
REQ-009 Port in_data_vld, input, 1 bit: in_data is valid.
REQ-010 Port in_data_rdy, output, 1 bit: the block can accept a sample this cycle.
REQ-011 Port coef_wr, input, 1 bit: coefficient write strobe.
REQ-012 Port coef_addr, input, AW bits: tap index for the write.
REQ-013 Port coef_data, input, COEF_W bits: signed coefficient value.
REQ-014 Port out_data, output, DATA_W bits: signed, rounded, saturated filter output.
REQ-015 Port out_data_vld, output, 1 bit: single-cycle pulse marking out_data as valid.
REQ-016 Port out_sat, output, 1 bit: the current out_data was clipped; valid only while out_data_vld=1.

Function
REQ-017 The block shall hold a TAPS-deep delay line x[0..TAPS-1] and a coefficient bank c[0..TAPS-1].
REQ-018 The block shall use one time-shared multiplier and an FSM with three states: IDLE, MAC and OUT.
REQ-019 in_data_rdy shall be 1 only in IDLE.
- A sample is accepted on a clock edge with in_data_vld=1 and in_data_rdy=1.
REQ-020 On accept:
- x[k] <= x[k-1] for k >= 1, and x[0] <= in_data;
- acc <= 0 and idx <= 0;
- the FSM moves to MAC.
REQ-021 In MAC, each cycle shall perform acc <= acc + x[idx]*c[idx] as a full-precision signed operation and increment idx.
- After the idx = TAPS-1 product, the FSM moves to OUT.
REQ-022 In OUT, the block shall:
- compute r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT (arithmetic shift);
- clamp r to [-2^(DATA_W-1), 2^(DATA_W-1)-1];
- register the clamped value on out_data and set out_data_vld=1 for exactly one cycle;
- set out_sat=1 if clamping occurred;
- return to IDLE.
REQ-023 Latency: for a sample accepted at edge N, out_data_vld shall be high during the cycle after edge N+TAPS+1. Maximum throughput is one sample per TAPS+2 cycles.
REQ-024 out_data shall hold its last value between pulses. out_sat shall be 0 whenever out_data_vld=0.
REQ-025 A coefficient write (c[coef_addr] <= coef_data) shall take effect only when coef_wr=1 in IDLE. Writes in MAC or OUT shall be ignored.
REQ-026 When a write and a sample accept occur on the same edge, the write shall complete first, and that sample's MAC shall use the new coefficient.
REQ-027 in_data_vld held high while in_data_rdy=0 shall not be consumed. The sample shall be accepted on the first IDLE edge and never duplicated.
REQ-028 The accumulator width ACC_W shall make overflow impossible for any legal parameter set.

Reset
REQ-029 While reset=0, the block shall force:
- FSM=IDLE, acc=0, idx=0;
- all x[k]=0;
- out_data=0, out_data_vld=0, out_sat=0;
- c[0] = 2^OUT_SHIFT and c[k]=0 for k>0 (identity filter).
REQ-030 Reset asserted during MAC or OUT shall abort the computation: no out_data_vld pulse, delay line cleared.
REQ-031 After reset release, the first sample may be accepted on the first rising edge, since in_data_rdy=1.

Verification
REQ-032 Identity: after reset, feed 5, then -3, then 100. Outputs shall be 5, -3, 100, each exactly TAPS+1 cycles after its accept, with out_sat=0.
REQ-033 Impulse: load c[k] = k+1, feed 64 followed by TAPS-1 zeros. Outputs shall be 1, 2, ..., TAPS, since (64*c + 32)>>6 = c.
REQ-034 Saturation: load all c = 63, feed 127 for TAPS samples. The final output shall be 127 with out_sat=1. With -128 input, the output shall be -128 with out_sat=1.
REQ-035 Rounding: identity coefficients c[0]=65, feed 63; acc=4095 and (4095+32)>>6 = 64, so the output shall be 64.
REQ-036 Handshake and ignored write: hold in_data_vld=1 with values 1, 2, 3 presented only when in_data_rdy=1, and pulse coef_wr (c[0]=0) during MAC. Exactly three outputs 1, 2, 3 shall appear and c[0] shall remain 64.
REQ-037 Reset mid-operation: assert reset=0 at MAC cycle 3. No out_data_vld pulse shall occur. After release, feeding 7 shall produce 7.
